// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: splits 64-bit fetch lines into 32-bit IR/NPC entries for decode.
// Build option: define FQ_BYPASS_EN to let an accepted line drive the slots in the same cycle when the queue is empty.
module inst_fetch_queue #(
    parameter int DEPTH      = 16,
    parameter int DISP_WIDTH = 2,
    parameter int CW         = $clog2(DISP_WIDTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush_in,
    input  logic                        if_valid_in,
    input  logic [63:0]                 if_pc_in,
    input  logic [63:0]                 if_line_in,
    output logic                        if_ready_out,
    output logic [$clog2(DEPTH):0]      fq_count_out,
    input  logic [CW-1:0]               disp_count_in,
    output logic [DISP_WIDTH-1:0]       fq_valid_out,
    output logic [32*DISP_WIDTH-1:0]    fq_ir_out,
    output logic [64*DISP_WIDTH-1:0]    fq_npc_out
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [31:0]     ir_mem  [DEPTH];
    logic [63:0]     npc_mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CNTW-1:0] count;

    logic [31:0]     in_ir  [2];
    logic [63:0]     in_npc [2];
    logic [1:0]      in_num;
    logic            accept;
    logic            bypass;
    logic [CW-1:0]   n_vld;
    logic [CW-1:0]   deq;
    logic [CW-1:0]   q_deq;
    logic [1:0]      enq_n;
    logic            skip;
    logic [31:0]     wr_ir  [2];
    logic [63:0]     wr_npc [2];

    // A full line needs two free entries even when only one word is wanted.
    assign if_ready_out = !reset && (count <= CNTW'(DEPTH - 2));
    assign accept       = if_valid_in && if_ready_out && !flush_in;
    assign fq_count_out = count;

    always_comb begin
        in_ir[0]  = if_pc_in[2] ? if_line_in[63:32] : if_line_in[31:0];
        in_npc[0] = if_pc_in + 64'd4;
        in_ir[1]  = if_line_in[63:32];
        in_npc[1] = if_pc_in + 64'd8;
        in_num    = if_pc_in[2] ? 2'd1 : 2'd2;
    end

`ifdef FQ_BYPASS_EN
    assign bypass = accept && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        fq_valid_out = '0;
        fq_ir_out    = '0;
        fq_npc_out   = '0;
        n_vld        = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
`ifdef FQ_BYPASS_EN
            if (bypass) begin
                if (i < int'(in_num)) begin
                    fq_valid_out[i]       = 1'b1;
                    fq_ir_out[32*i +: 32] = in_ir[1'(i)];
                    fq_npc_out[64*i +: 64] = in_npc[1'(i)];
                    n_vld                 = n_vld + CW'(1);
                end
            end else
`endif
            if (!reset && (count > CNTW'(i))) begin
                fq_valid_out[i]        = 1'b1;
                fq_ir_out[32*i +: 32]  = ir_mem[head + AW'(i)];
                fq_npc_out[64*i +: 64] = npc_mem[head + AW'(i)];
                n_vld                  = n_vld + CW'(1);
            end
        end
    end

    // Over-requests from decode are clamped to what is actually presented.
    always_comb begin
        deq   = (disp_count_in < n_vld) ? disp_count_in : n_vld;
        q_deq = bypass ? '0 : deq;
        skip  = bypass && (deq != '0);
        if (!accept)
            enq_n = 2'd0;
        else if (bypass)
            enq_n = in_num - 2'(deq);
        else
            enq_n = in_num;
        wr_ir[0]  = skip ? in_ir[1]  : in_ir[0];
        wr_npc[0] = skip ? in_npc[1] : in_npc[0];
        wr_ir[1]  = in_ir[1];
        wr_npc[1] = in_npc[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(q_deq);
            tail  <= tail + AW'(enq_n);
            count <= count + CNTW'(enq_n) - CNTW'(q_deq);
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (2'(k) < enq_n) begin
                ir_mem[tail + AW'(k)]  <= wr_ir[k];
                npc_mem[tail + AW'(k)] <= wr_npc[k];
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue (DEPTH=16, DISP_WIDTH=2): queue-based reference model plus directed scenarios.
module tb_inst_fetch_queue;
    logic         clock;
    logic         reset;
    logic         flush_in;
    logic         if_valid_in;
    logic [63:0]  if_pc_in;
    logic [63:0]  if_line_in;
    logic         if_ready_out;
    logic [4:0]   fq_count_out;
    logic [1:0]   disp_count_in;
    logic [1:0]   fq_valid_out;
    logic [63:0]  fq_ir_out;
    logic [127:0] fq_npc_out;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(.DEPTH(16), .DISP_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .flush_in(flush_in),
        .if_valid_in(if_valid_in), .if_pc_in(if_pc_in), .if_line_in(if_line_in),
        .if_ready_out(if_ready_out), .fq_count_out(fq_count_out),
        .disp_count_in(disp_count_in), .fq_valid_out(fq_valid_out),
        .fq_ir_out(fq_ir_out), .fq_npc_out(fq_npc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] ir;
        logic [63:0] npc;
    } ent_t;

    ent_t mq[$];
    bit   armed = 0;

    // Reference model: checks presented state, then applies this cycle's inputs.
    always @(negedge clock) begin : model
        logic exp_ready;
        logic acc;
        int   nv;
        int   d;
        exp_ready = !reset && ((16 - mq.size()) >= 2);
        if (armed) begin
            chk("ready", 64'(if_ready_out), 64'(exp_ready));
            chk("count", 64'(fq_count_out), 64'(mq.size()));
            for (int i = 0; i < 2; i++) begin
                if (!reset && i < mq.size()) begin
                    chk("slot_valid", 64'(fq_valid_out[i]), 64'd1);
                    chk("slot_ir", 64'(fq_ir_out[32*i +: 32]), 64'(mq[i].ir));
                    chk("slot_npc", fq_npc_out[64*i +: 64], mq[i].npc);
                end else begin
                    chk("slot_valid", 64'(fq_valid_out[i]), 64'd0);
                    chk("slot_ir", 64'(fq_ir_out[32*i +: 32]), 64'd0);
                    chk("slot_npc", fq_npc_out[64*i +: 64], 64'd0);
                end
            end
        end
        nv  = (mq.size() < 2) ? mq.size() : 2;
        d   = (int'(disp_count_in) < nv) ? int'(disp_count_in) : nv;
        acc = if_valid_in && exp_ready && !flush_in;
        if (reset || flush_in) begin
            mq.delete();
        end else begin
            repeat (d) void'(mq.pop_front());
            if (acc) begin
                if (!if_pc_in[2]) begin
                    mq.push_back({if_line_in[31:0], if_pc_in + 64'd4});
                    mq.push_back({if_line_in[63:32], if_pc_in + 64'd8});
                end else begin
                    mq.push_back({if_line_in[63:32], if_pc_in + 64'd4});
                end
            end
        end
        if (reset) armed = 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_line(input logic [63:0] pc, input logic [63:0] ln);
        if_valid_in = 1'b1;
        if_pc_in    = pc;
        if_line_in  = ln;
    endtask

    initial begin
        reset = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_pc_in = '0; if_line_in = '0; disp_count_in = '0;
        step(); step();
        chk("rst_count", 64'(fq_count_out), 64'd0);
        chk("rst_valid", 64'(fq_valid_out), 64'd0);
        chk("rst_ready", 64'(if_ready_out), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_idle", 64'(if_ready_out), 64'd1);

        drive_line(64'h0, 64'h47FF041F_A4000008);
        step(); if_valid_in = 1'b0;
        chk("l0_count", 64'(fq_count_out), 64'd2);
        chk("l0_valid", 64'(fq_valid_out), 64'd3);
        chk("l0_ir0", 64'(fq_ir_out[31:0]), 64'hA4000008);
        chk("l0_npc0", fq_npc_out[63:0], 64'h4);
        chk("l0_ir1", 64'(fq_ir_out[63:32]), 64'h47FF041F);
        chk("l0_npc1", fq_npc_out[127:64], 64'h8);

        drive_line(64'h104, 64'hDEADBEEF_11111111);
        step(); if_valid_in = 1'b0;
        chk("odd_count", 64'(fq_count_out), 64'd3);
        disp_count_in = 2'd2;
        step();
        chk("odd_count_after_deq", 64'(fq_count_out), 64'd1);
        chk("odd_ir", 64'(fq_ir_out[31:0]), 64'hDEADBEEF);
        chk("odd_npc", fq_npc_out[63:0], 64'h108);
        chk("odd_valid", 64'(fq_valid_out), 64'd1);
        step(); disp_count_in = 2'd0;
        chk("clamp_count", 64'(fq_count_out), 64'd0);
        chk("clamp_valid", 64'(fq_valid_out), 64'd0);

        for (int k = 0; k < 7; k++) begin
            drive_line(64'h300 + 64'(8*k), {32'hC0000001 + 32'(2*k), 32'hC0000000 + 32'(2*k)});
            step();
        end
        chk("fill14_count", 64'(fq_count_out), 64'd14);
        chk("fill14_ready", 64'(if_ready_out), 64'd1);
        drive_line(64'h338, 64'hC000000F_C000000E);
        step();
        chk("full_count", 64'(fq_count_out), 64'd16);
        chk("full_ready", 64'(if_ready_out), 64'd0);
        drive_line(64'h900, 64'hEEEEEEEE_EEEEEEEE);
        step(); step();
        chk("full_hold", 64'(fq_count_out), 64'd16);
        disp_count_in = 2'd1;
        step();
        chk("c15_count", 64'(fq_count_out), 64'd15);
        chk("c15_ready", 64'(if_ready_out), 64'd0);
        step();
        chk("c14_count", 64'(fq_count_out), 64'd14);
        if_valid_in = 1'b0;
        disp_count_in = 2'd2;
        repeat (4) step();
        chk("drain_count", 64'(fq_count_out), 64'd6);

        for (int k = 0; k < 6; k++) begin
            drive_line(64'h400 + 64'(8*k), {32'hD0000001 + 32'(2*k), 32'hD0000000 + 32'(2*k)});
            step();
            chk("steady_count", 64'(fq_count_out), 64'd6);
        end
        if_valid_in = 1'b0; disp_count_in = 2'd0;
        chk("wrap_ir0", 64'(fq_ir_out[31:0]), 64'hD0000006);
        chk("wrap_npc0", fq_npc_out[63:0], 64'h41C);

        drive_line(64'h504, 64'hA5A5A5A5_5A5A5A5A);
        step();
        drive_line(64'h508, 64'hB6B6B6B6_6B6B6B6B);
        step();
        chk("pre_flush_count", 64'(fq_count_out), 64'd9);
        flush_in = 1'b1; disp_count_in = 2'd2;
        drive_line(64'h510, 64'h12345678_9ABCDEF0);
        step();
        flush_in = 1'b0; if_valid_in = 1'b0; disp_count_in = 2'd0;
        chk("flush_count", 64'(fq_count_out), 64'd0);
        chk("flush_valid", 64'(fq_valid_out), 64'd0);

        drive_line(64'h600, 64'h0000AAAA_0000BBBB);
        step();
        drive_line(64'h608, 64'h0000CCCC_0000DDDD);
        step();
        chk("pre_reset_count", 64'(fq_count_out), 64'd4);
        reset = 1'b1; disp_count_in = 2'd1;
        step();
        chk("mid_rst_count", 64'(fq_count_out), 64'd0);
        chk("mid_rst_valid", 64'(fq_valid_out), 64'd0);
        chk("mid_rst_ir", fq_ir_out, 64'd0);
        chk("mid_rst_npc", fq_npc_out[63:0] | fq_npc_out[127:64], 64'd0);
        chk("mid_rst_ready", 64'(if_ready_out), 64'd0);
        reset = 1'b0; if_valid_in = 1'b0; disp_count_in = 2'd0;
        step();
        chk("post_rst_count", 64'(fq_count_out), 64'd0);
        chk("post_rst_ready", 64'(if_ready_out), 64'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
